memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, ports listed first: clk in 1 rising-edge clock; rst in 1 asynchronous active-high reset.
REQ-002 The block SHALL provide valid_in, in, 1: an instruction is present on the execute/memory inputs this cycle.
REQ-003 The block SHALL provide wbs_in, in, 1: write-back select; 0 selects the ALU result, 1 selects the load data.
REQ-004 The block SHALL provide wme_in, in, 1: register-file write enable for write-back.
REQ-005 The block SHALL provide mm_in, in, 2: memory mode; 00 none, 01 load word, 10 load low byte zero-extended, 11 treated as 00.
REQ-006 The block SHALL provide wm_in, in, 1: store enable.
REQ-007 The block SHALL provide ni_in, in, 1: next-instruction flag, passed through to write-back.
REQ-008 The block SHALL provide ALUresult_in, in, 16: memory address (bits 7:0) or pass-through result.
REQ-009 The block SHALL provide memData_in, in, 16: store data.
REQ-010 The block SHALL provide stall_out, out, 1: upstream stages must hold their inputs this cycle.
REQ-011 The block SHALL provide the following write-back outputs, all registered:
- valid_out, out, 1
- wbs_out, out, 1
- wme_out, out, 1
- ni_out, out, 1
- ALUresult_out, out, 16
- readData_out, out, 16

Function
REQ-012 The block SHALL contain a 256 x 16 data memory addressed by ALUresult_in[7:0], with a synchronous write and a registered read.
REQ-013 When valid_in=1, mm_in is 00 or 11, and no stall is active, the block SHALL register all pass-through fields into the outputs on the next rising edge (1-cycle latency), with readData_out=0.
REQ-014 A store (valid_in=1, wm_in=1) SHALL write memData_in to the addressed memory word on that rising edge, with no stall. If mm_in is nonzero at the same time, the store SHALL take effect and mm_in SHALL be ignored.
REQ-015 The block SHALL use a two-state FSM:
- RUN: a load (valid_in=1, mm_in 01/10, wm_in=0) SHALL assert stall_out combinationally for that cycle and move to LOAD_WAIT.
- LOAD_WAIT: stall_out=0, the block SHALL drive the write-back outputs with the read data and valid_out=1, then return to RUN.
REQ-016 Load latency SHALL be 2 cycles from load acceptance to valid_out. The upstream stage SHALL hold its inputs stable while stall_out=1, and the block SHALL use the held inputs in LOAD_WAIT.
REQ-017 While in RUN with stall_out asserted, the block SHALL register valid_out=0, a bubble.
REQ-018 A mm_in=10 load SHALL return {8'h00, mem[addr][7:0]}. A mm_in=01 load SHALL return the full word.
REQ-019 When valid_in=0, the block SHALL produce valid_out=0 on the next edge, clear wme_out, and leave the memory unmodified.
REQ-020 A load that immediately follows a store to the same address SHALL return the newly stored value.

Reset
REQ-021 Asserting rst SHALL immediately force the FSM to RUN and clear all registered outputs to 0. stall_out SHALL be 0 while rst=1.
REQ-022 Reset SHALL NOT clear the memory contents. A load in progress when reset is asserted SHALL be abandoned with no output.
REQ-023 After rst is deasserted, the first valid instruction SHALL be processed normally on the next rising edge.

Configuration
REQ-024 The macro MEM_RANGE_CHECK_EN SHALL be defined to compile in out-of-range checking.
- Defined: the block SHALL add the output mem_err_out, out, 1, registered and reset to 0. Any load or store with ALUresult_in[15:8] nonzero SHALL suppress the memory write, return readData_out=0, and pulse mem_err_out=1 together with that instruction's valid_out.
- Undefined: the port SHALL be absent and the address SHALL be truncated to bits 7:0.

Verification
REQ-025 The bench SHALL cover a pass-through ALU op: ALUresult_in=16'h0050, mm_in=00, wme_in=1 -> next edge ALUresult_out=16'h0050, wme_out=1, valid_out=1, stall_out never set.
REQ-026 The bench SHALL cover store then load: store 16'hABCD to address 16'h0003, then load word from 16'h0003 -> stall_out=1 for 1 cycle, then readData_out=16'hABCD, valid_out=1.
REQ-027 The bench SHALL cover a byte load: mem[16'h0007]=16'h12F4, mm_in=10 -> readData_out=16'h00F4.
REQ-028 The bench SHALL cover reset mid-load: assert rst during LOAD_WAIT -> outputs 0 and FSM in RUN immediately; mem[16'h0003] still reads 16'hABCD afterwards.
REQ-029 The bench SHALL cover a bubble: valid_in=0 with wme_in=1 and wm_in=1 -> valid_out=0, wme_out=0, memory unchanged.
REQ-030 With MEM_RANGE_CHECK_EN defined, the bench SHALL cover an out-of-range store: store to 16'h0103 -> mem_err_out=1, and mem[16'h0003] is unchanged.

Source files
------------

// File: rtl/memory_stage_if.sv
// Execute/memory to write-back bundle for memory_stage.
// mem_err_out exists only when MEM_RANGE_CHECK_EN is defined.
interface memory_stage_if;
  logic        valid_in;
  logic        wbs_in;
  logic        wme_in;
  logic [1:0]  mm_in;
  logic        wm_in;
  logic        ni_in;
  logic [15:0] ALUresult_in;
  logic [15:0] memData_in;
  logic        stall_out;
  logic        valid_out;
  logic        wbs_out;
  logic        wme_out;
  logic        ni_out;
  logic [15:0] ALUresult_out;
  logic [15:0] readData_out;
`ifdef MEM_RANGE_CHECK_EN
  logic        mem_err_out;
`endif

  // Handshake: valid_in qualifies every *_in field; while stall_out=1 the
  // upstream stage holds all *_in fields stable for the following cycle.
  // valid_out qualifies the registered write-back fields.
  modport master (
    output valid_in, wbs_in, wme_in, mm_in, wm_in, ni_in, ALUresult_in, memData_in,
    input  stall_out, valid_out, wbs_out, wme_out, ni_out, ALUresult_out, readData_out
`ifdef MEM_RANGE_CHECK_EN
    , input mem_err_out
`endif
  );

  modport slave (
    input  valid_in, wbs_in, wme_in, mm_in, wm_in, ni_in, ALUresult_in, memData_in,
    output stall_out, valid_out, wbs_out, wme_out, ni_out, ALUresult_out, readData_out
`ifdef MEM_RANGE_CHECK_EN
    , output mem_err_out
`endif
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: 256x16 data memory, one-bubble stall on loads.
// Define MEM_RANGE_CHECK_EN to reject addresses with nonzero bits 15:8.
module memory_stage (
  input  logic          clk,
  input  logic          rst,
  memory_stage_if.slave bus,
  output logic          state_dbg
);

  typedef enum logic {RUN = 1'b0, LOAD_WAIT = 1'b1} state_t;

  state_t      state;
  logic [15:0] mem [256];
  logic [15:0] rd_q;
  logic [7:0]  addr;
  logic        addr_err;
  logic        is_load;
  logic        mem_we;
  logic [15:0] load_val;

  assign addr = bus.ALUresult_in[7:0];
`ifdef MEM_RANGE_CHECK_EN
  assign addr_err = |bus.ALUresult_in[15:8];
`else
  assign addr_err = 1'b0;
`endif

  // A store wins over any memory mode presented alongside it.
  assign is_load  = bus.valid_in && !bus.wm_in && (bus.mm_in == 2'b01 || bus.mm_in == 2'b10);
  assign mem_we   = bus.valid_in && bus.wm_in && (state == RUN) && !addr_err;
  assign bus.stall_out = !rst && (state == RUN) && is_load;
  assign load_val = addr_err ? 16'h0000 :
                    (bus.mm_in == 2'b10) ? {8'h00, rd_q[7:0]} : rd_q;
  assign state_dbg = state;

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= bus.memData_in;
    rd_q <= mem[addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= RUN;
      bus.valid_out     <= 1'b0;
      bus.wbs_out       <= 1'b0;
      bus.wme_out       <= 1'b0;
      bus.ni_out        <= 1'b0;
      bus.ALUresult_out <= 16'h0000;
      bus.readData_out  <= 16'h0000;
`ifdef MEM_RANGE_CHECK_EN
      bus.mem_err_out   <= 1'b0;
`endif
    end else begin
      bus.wbs_out       <= bus.wbs_in;
      bus.ni_out        <= bus.ni_in;
      bus.ALUresult_out <= bus.ALUresult_in;
      case (state)
        RUN: begin
          bus.readData_out <= 16'h0000;
          if (bus.valid_in && !is_load) begin
            bus.valid_out <= 1'b1;
            bus.wme_out   <= bus.wme_in;
          end else begin
            bus.valid_out <= 1'b0;
            bus.wme_out   <= 1'b0;
          end
`ifdef MEM_RANGE_CHECK_EN
          bus.mem_err_out <= bus.valid_in && bus.wm_in && addr_err;
`endif
          if (is_load) state <= LOAD_WAIT;
        end
        LOAD_WAIT: begin
          // Upstream still holds the load fields; rd_q was captured last edge.
          bus.valid_out    <= 1'b1;
          bus.wme_out      <= bus.wme_in;
          bus.readData_out <= load_val;
`ifdef MEM_RANGE_CHECK_EN
          bus.mem_err_out  <= addr_err;
`endif
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
// Covers MEM_RANGE_CHECK_EN cases when that macro is defined.
module tb_memory_stage;
  logic clk;
  logic rst;
  logic state_dbg;
  int   n_checks;
  int   n_fail;

  memory_stage_if bus ();

  memory_stage dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic wbs, input logic wme, input logic [1:0] mm,
                       input logic wm, input logic ni, input logic [15:0] alu, input logic [15:0] data);
    bus.valid_in     = valid;
    bus.wbs_in       = wbs;
    bus.wme_in       = wme;
    bus.mm_in        = mm;
    bus.wm_in        = wm;
    bus.ni_in        = ni;
    bus.ALUresult_in = alu;
    bus.memData_in   = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic do_store(input string tag, input logic [15:0] alu, input logic [15:0] data,
                          input logic [1:0] mm, input logic exp_err);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, mm, 1'b1, 1'b0, alu, data);
    #1 check({tag, "_stall"}, bus.stall_out, 1'b0);
    @(posedge clk); #1;
    check({tag, "_valid"}, bus.valid_out, 1'b1);
    check({tag, "_rdata"}, bus.readData_out, 16'h0000);
`ifdef MEM_RANGE_CHECK_EN
    check({tag, "_err"}, bus.mem_err_out, exp_err);
`else
    check({tag, "_err_nc"}, exp_err, 1'b0);
`endif
  endtask

  task automatic do_load(input string tag, input logic [15:0] alu, input logic [1:0] mm,
                         input logic [15:0] exp, input logic exp_err);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, mm, 1'b0, 1'b1, alu, 16'h0000);
    #1 check({tag, "_stall1"}, bus.stall_out, 1'b1);
    @(posedge clk); #1;
    check({tag, "_bubble"}, bus.valid_out, 1'b0);
    check({tag, "_state_wait"}, state_dbg, 1'b1);
    @(negedge clk);
    #1 check({tag, "_stall0"}, bus.stall_out, 1'b0);
    @(posedge clk); #1;
    check({tag, "_valid"}, bus.valid_out, 1'b1);
    check({tag, "_rdata"}, bus.readData_out, exp);
    check({tag, "_wme"}, bus.wme_out, 1'b1);
    check({tag, "_state_run"}, state_dbg, 1'b0);
`ifdef MEM_RANGE_CHECK_EN
    check({tag, "_err"}, bus.mem_err_out, exp_err);
`endif
    @(negedge clk);
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    idle();
    #1;
    // stall must stay low in reset even with a load presented
    drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 16'h0003, 16'h0000);
    #1;
    check("rst_stall", bus.stall_out, 1'b0);
    check("rst_valid", bus.valid_out, 1'b0);
    check("rst_alu", bus.ALUresult_out, 16'h0000);
    check("rst_state", state_dbg, 1'b0);
    @(posedge clk); #1;
    check("rst_hold_valid", bus.valid_out, 1'b0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // pass-through ALU op
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 16'h0050, 16'h0000);
    #1 check("pt_stall", bus.stall_out, 1'b0);
    @(posedge clk); #1;
    check("pt_valid", bus.valid_out, 1'b1);
    check("pt_alu", bus.ALUresult_out, 16'h0050);
    check("pt_wme", bus.wme_out, 1'b1);
    check("pt_ni", bus.ni_out, 1'b1);
    check("pt_rdata", bus.readData_out, 16'h0000);

    // mm=11 behaves like no memory op
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 16'h1234, 16'h0000);
    #1 check("mm11_stall", bus.stall_out, 1'b0);
    @(posedge clk); #1;
    check("mm11_valid", bus.valid_out, 1'b1);
    check("mm11_wbs", bus.wbs_out, 1'b1);
    check("mm11_alu", bus.ALUresult_out, 16'h1234);

    // store with mm set (store wins), then back-to-back load
    do_store("st3", 16'h0003, 16'hABCD, 2'b01, 1'b0);
    do_load("ldw3", 16'h0003, 2'b01, 16'hABCD, 1'b0);

    do_store("st7", 16'h0007, 16'h12F4, 2'b00, 1'b0);
    do_load("ldb7", 16'h0007, 2'b10, 16'h00F4, 1'b0);
    do_load("ldw7", 16'h0007, 2'b01, 16'h12F4, 1'b0);

    // bubble: no valid, no write
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 16'h0003, 16'h5555);
    @(posedge clk); #1;
    check("bub_valid", bus.valid_out, 1'b0);
    check("bub_wme", bus.wme_out, 1'b0);
    do_load("bub_ld3", 16'h0003, 2'b01, 16'hABCD, 1'b0);

    // reset during LOAD_WAIT
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 16'h0003, 16'h0000);
    @(posedge clk); #1;
    check("rml_state_wait", state_dbg, 1'b1);
    check("rml_alu_pre", bus.ALUresult_out, 16'h0003);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rml_state", state_dbg, 1'b0);
    check("rml_alu", bus.ALUresult_out, 16'h0000);
    check("rml_ni", bus.ni_out, 1'b0);
    check("rml_stall", bus.stall_out, 1'b0);
    @(posedge clk); #1;
    check("rml_no_out", bus.valid_out, 1'b0);
    @(negedge clk);
    idle();
    rst = 1'b0;
    do_load("rml_ld3", 16'h0003, 2'b01, 16'hABCD, 1'b0);

`ifdef MEM_RANGE_CHECK_EN
    do_store("oor_st", 16'h0103, 16'h9999, 2'b00, 1'b1);
    do_load("oor_chk3", 16'h0003, 2'b01, 16'hABCD, 1'b0);
    do_load("oor_ld", 16'h0107, 2'b01, 16'h0000, 1'b1);
`else
    // upper address bits are ignored: 0x0103 aliases word 3
    do_store("trunc_st", 16'h0103, 16'h9999, 2'b00, 1'b0);
    do_load("trunc_ld3", 16'h0003, 2'b01, 16'h9999, 1'b0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
